motor_pwm_driver: RTL and testbench
===================================

Name: motor_pwm_driver

Overview:
Consumer end of the line-tracker interface. Takes the 3-bit steering classification produced by the tracker sensor block and drives the two DC-motor H-bridge channels (left and right) with PWM and direction pins. Duty changes are slew-limited, and the direction-reversal interlock prevents shoot-through and current spikes. The block sits between the tracker sensor block and the board-level motor driver pins.

Parameters:
PWM_PERIOD, 1000, PWM period in clk cycles (counter runs 0..PWM_PERIOD-1)
RAMP_DIV, 10000, clk cycles per ramp tick
RAMP_STEP, 10, duty change per ramp tick (saturating toward target, never overshoots)
DUTY_FAST, 750, outer-wheel duty
DUTY_SLOW, 400, inner-wheel duty on gentle turns
DUTY_SPIN, 500, duty for both wheels during pivot recovery

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low ramps both motors to 0
state  in  3  tracker class: 0 LLLLEFT, 1 LEFT, 2 left, 3 right, 4 RIGHT, 5 RRRRIGHT, 6/7 illegal
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
dir_l  out  2  left H-bridge {IN1,IN2}: 2'b10 forward, 2'b01 reverse
dir_r  out  2  right H-bridge, same encoding
settled  out  1  high when both channels have reached their target duty and direction

Behaviour:
- Clock: clk. Reset: reset, synchronous, active-high.
- Reset values: pwm_l=pwm_r=0, dir_l=dir_r=2'b10, settled=0. All duty registers, PWM counter, prescaler, and sampled state are 0. Reset mid-ramp takes effect on the next edge.
- The state input is registered once, giving 1 cycle of latency before targets change.
- Target table, as (dir, duty) for left and right wheels:
  - 0: L (rev, SPIN), R (fwd, SPIN)
  - 1: L (fwd, 0), R (fwd, FAST)
  - 2: L (fwd, SLOW), R (fwd, FAST)
  - 3: L (fwd, FAST), R (fwd, SLOW)
  - 4: L (fwd, FAST), R (fwd, 0)
  - 5: L (fwd, SPIN), R (rev, SPIN)
  - 6/7: both targets duty 0, each direction target equal to its current direction
  - enable=0 overrides the table with the 6/7 behaviour.
- Ramp: the prescaler counts 0..RAMP_DIV-1. On the tick cycle (count==RAMP_DIV-1), each channel's duty_cur moves toward its effective target by at most RAMP_STEP.
- Direction interlock, per channel:
  - When target dir differs from the current dir, the effective target duty is 0.
  - On the first cycle where duty_cur==0 and a direction mismatch exists, dir updates on the next edge.
  - Ramp-up toward the new target starts at the following tick.
  - dir never changes while duty_cur is nonzero.
- PWM:
  - The shared counter wraps at PWM_PERIOD-1.
  - Each channel latches duty_cur into duty_cmp only when counter==PWM_PERIOD-1, so there are no mid-period duty changes.
  - pwm output is registered: pwm <= (counter < duty_cmp).
  - duty_cmp=0 gives a constant 0; duty_cmp>=PWM_PERIOD gives a constant 1.
- settled is registered: high when, for both channels, duty_cur equals the effective table target and dir equals the table dir.
- Simultaneous state change and ramp tick: the tick uses the target computed from the already-registered state.

Decomposition:
- Shared package holds:
  - the tracker state encoding constants (0..5), shared with the tracker sensor block
  - the DIR_FWD and DIR_REV encodings
  - the default duty constants
- One sub-module, motor_channel, is instantiated twice. It contains:
  - the duty_cur ramp register
  - the dir register and interlock
  - the duty_cmp latch
  - the pwm compare flop
- It takes the shared ramp_tick, period_end, and counter value, plus the target dir and duty.
- The top level holds:
  - the state register
  - the target table
  - the PWM counter
  - the ramp prescaler
  - the settled logic

Test Plan:
(Sim parameters: PWM_PERIOD=10, RAMP_DIV=2, RAMP_STEP=1, FAST=8, SLOW=4, SPIN=5.)
1. Reset held 3 cycles -> pwm_l=pwm_r=0, dir_l=dir_r=2'b10, settled=0. Release, enable=1, state=2 -> duty_l reaches 4 after 4 ticks (8 cycles) and duty_r reaches 8 after 16 cycles. settled rises, and from the next full period pwm_r is high 8 of 10 cycles and pwm_l 4 of 10.
2. Settled at state 2, then state=0 -> duty_l ramps 4,3,2,1,0 with dir_l held at 2'b10. dir_l becomes 2'b01 one cycle after duty_l==0, then duty_l ramps to 5. duty_r ramps 8->5. settled is low throughout the transition.
3. Settled at state 3, then enable=0 -> both duties ramp to 0 at 1 per tick with dirs unchanged. pwm_l/pwm_r stay 0 after the next period boundary. settled goes high once both are 0.
4. state=7 while running at state 4 -> duties ramp to 0 and dirs are held. Return to state=4 -> ramps back to L=8, R=0.
5. Assert reset mid-ramp (duty_r=5) -> next edge gives all outputs at reset values. Deassert -> ramp restarts from 0.
6. Change state 2->3 at PWM counter=3 with the ramp forcing duty_cur change -> the pwm duty pattern of the current period is unchanged, and the new duty_cmp applies from counter=0 of the next period.

Source files
------------

// File: rtl/motor_pwm_driver_pkg.sv
// Shared definitions for the line-tracker to motor-driver path: tracker class
// encoding, H-bridge direction encoding, duty defaults and the channel target type.
package motor_pwm_driver_pkg;

    localparam int DUTY_W = 16;

    localparam logic [2:0] ST_LLLLEFT  = 3'd0;
    localparam logic [2:0] ST_LEFT_BIG = 3'd1;
    localparam logic [2:0] ST_LEFT     = 3'd2;
    localparam logic [2:0] ST_RIGHT    = 3'd3;
    localparam logic [2:0] ST_RIGHT_BIG= 3'd4;
    localparam logic [2:0] ST_RRRRIGHT = 3'd5;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    localparam int DEF_PWM_PERIOD = 1000;
    localparam int DEF_RAMP_DIV   = 10000;
    localparam int DEF_RAMP_STEP  = 10;
    localparam int DEF_DUTY_FAST  = 750;
    localparam int DEF_DUTY_SLOW  = 400;
    localparam int DEF_DUTY_SPIN  = 500;

    typedef struct packed {
        logic [1:0]        dir;
        logic [DUTY_W-1:0] duty;
    } target_t;

    function automatic target_t mk_tgt(logic [1:0] dir, int duty);
        return '{dir: dir, duty: DUTY_W'(duty)};
    endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Tracker-to-motor bundle: steering class and enable in, PWM/direction/settled out.
interface motor_pwm_driver_if;

    logic       enable;
    logic [2:0] state;
    logic       pwm_l;
    logic       pwm_r;
    logic [1:0] dir_l;
    logic [1:0] dir_r;
    logic       settled;

    modport master (
        output enable, state,
        input  pwm_l, pwm_r, dir_l, dir_r, settled
    );

    modport slave (
        input  enable, state,
        output pwm_l, pwm_r, dir_l, dir_r, settled
    );

endinterface

// File: rtl/motor_pwm_driver_motor_channel.sv
// One H-bridge channel: slew-limited duty ramp, reversal interlock,
// period-aligned duty latch and registered PWM compare.
module motor_channel
    import motor_pwm_driver_pkg::*;
#(
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ramp_tick,
    input  logic              i_period_end,
    input  logic [DUTY_W-1:0] i_cnt,
    input  target_t           i_tgt,
    output logic [DUTY_W-1:0] o_duty,
    output logic [1:0]        o_dir,
    output logic              o_pwm
);

    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_cmp;
    logic [1:0]        r_dir;
    logic              r_pwm;
    logic              w_mismatch;
    logic [DUTY_W-1:0] w_eff;
    logic [DUTY_W-1:0] w_next;

    // A pending reversal forces the duty down to zero before the bridge flips.
    assign w_mismatch = (i_tgt.dir != r_dir);
    assign w_eff      = w_mismatch ? '0 : i_tgt.duty;

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_duty;
        if (r_duty < w_eff) begin
            w_next = ((w_eff - r_duty) > STEP) ? r_duty + STEP : w_eff;
        end else if (r_duty > w_eff) begin
            w_next = ((r_duty - w_eff) > STEP) ? r_duty - STEP : w_eff;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty <= '0;
            r_cmp  <= '0;
            r_dir  <= DIR_FWD;
            r_pwm  <= 1'b0;
        end else begin
            if (i_ramp_tick)
                r_duty <= w_next;
            if (w_mismatch && (r_duty == '0))
                r_dir <= i_tgt.dir;
            if (i_period_end)
                r_cmp <= r_duty;
            r_pwm <= (i_cnt < r_cmp);
        end
    end

    assign o_duty = r_duty;
    assign o_dir  = r_dir;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/motor_pwm_driver.sv
// Maps the tracker steering class onto two slew-limited, interlocked PWM
// motor channels sharing one PWM counter and one ramp prescaler.
module motor_pwm_driver
    import motor_pwm_driver_pkg::*;
#(
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int RAMP_DIV   = DEF_RAMP_DIV,
    parameter int RAMP_STEP  = DEF_RAMP_STEP,
    parameter int DUTY_FAST  = DEF_DUTY_FAST,
    parameter int DUTY_SLOW  = DEF_DUTY_SLOW,
    parameter int DUTY_SPIN  = DEF_DUTY_SPIN
) (
    input  logic              clk,
    input  logic              reset,
    motor_pwm_driver_if.slave bus
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [2:0]        r_state;
    logic [DUTY_W-1:0] r_cnt;
    logic [PRE_W-1:0]  r_pre;
    logic              r_settled;

    logic              w_period_end;
    logic              w_ramp_tick;
    target_t           w_tgt_l;
    target_t           w_tgt_r;
    logic [DUTY_W-1:0] w_duty_l;
    logic [DUTY_W-1:0] w_duty_r;
    logic [1:0]        w_dir_l;
    logic [1:0]        w_dir_r;
    logic              w_pwm_l;
    logic              w_pwm_r;

    assign w_period_end = (r_cnt == DUTY_W'(PWM_PERIOD - 1));
    assign w_ramp_tick  = (r_pre == PRE_W'(RAMP_DIV - 1));

    // Disabled or illegal class: coast to zero without requesting a reversal.
    always_comb begin
        w_tgt_l = mk_tgt(w_dir_l, 0);
        w_tgt_r = mk_tgt(w_dir_r, 0);
        if (bus.enable) begin
            case (r_state)
                ST_LLLLEFT:   begin w_tgt_l = mk_tgt(DIR_REV, DUTY_SPIN); w_tgt_r = mk_tgt(DIR_FWD, DUTY_SPIN); end
                ST_LEFT_BIG:  begin w_tgt_l = mk_tgt(DIR_FWD, 0);         w_tgt_r = mk_tgt(DIR_FWD, DUTY_FAST); end
                ST_LEFT:      begin w_tgt_l = mk_tgt(DIR_FWD, DUTY_SLOW); w_tgt_r = mk_tgt(DIR_FWD, DUTY_FAST); end
                ST_RIGHT:     begin w_tgt_l = mk_tgt(DIR_FWD, DUTY_FAST); w_tgt_r = mk_tgt(DIR_FWD, DUTY_SLOW); end
                ST_RIGHT_BIG: begin w_tgt_l = mk_tgt(DIR_FWD, DUTY_FAST); w_tgt_r = mk_tgt(DIR_FWD, 0);         end
                ST_RRRRIGHT:  begin w_tgt_l = mk_tgt(DIR_FWD, DUTY_SPIN); w_tgt_r = mk_tgt(DIR_REV, DUTY_SPIN); end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= '0;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_settled <= 1'b0;
        end else begin
            r_state   <= bus.state;
            r_cnt     <= w_period_end ? '0 : r_cnt + 1'b1;
            r_pre     <= w_ramp_tick  ? '0 : r_pre + 1'b1;
            r_settled <= (w_duty_l == w_tgt_l.duty) && (w_dir_l == w_tgt_l.dir) &&
                         (w_duty_r == w_tgt_r.duty) && (w_dir_r == w_tgt_r.dir);
        end
    end

    motor_channel #(.RAMP_STEP(RAMP_STEP)) u_left (
        .clk          (clk),
        .reset        (reset),
        .i_ramp_tick  (w_ramp_tick),
        .i_period_end (w_period_end),
        .i_cnt        (r_cnt),
        .i_tgt        (w_tgt_l),
        .o_duty       (w_duty_l),
        .o_dir        (w_dir_l),
        .o_pwm        (w_pwm_l)
    );

    motor_channel #(.RAMP_STEP(RAMP_STEP)) u_right (
        .clk          (clk),
        .reset        (reset),
        .i_ramp_tick  (w_ramp_tick),
        .i_period_end (w_period_end),
        .i_cnt        (r_cnt),
        .i_tgt        (w_tgt_r),
        .o_duty       (w_duty_r),
        .o_dir        (w_dir_r),
        .o_pwm        (w_pwm_r)
    );

    assign bus.pwm_l   = w_pwm_l;
    assign bus.pwm_r   = w_pwm_r;
    assign bus.dir_l   = w_dir_l;
    assign bus.dir_r   = w_dir_r;
    assign bus.settled = r_settled;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized bench for motor_pwm_driver with a cycle-level behavioural model
// of the steering table, ramp, reversal interlock and PWM.
module tb_motor_pwm_driver;

    localparam int P    = 10;
    localparam int RD   = 2;
    localparam int STEP = 1;
    localparam int FAST = 8;
    localparam int SLOW = 4;
    localparam int SPIN = 5;
    localparam logic [1:0] FWD = 2'b10;
    localparam logic [1:0] REV = 2'b01;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    motor_pwm_driver_if bus ();

    motor_pwm_driver #(
        .PWM_PERIOD (P),
        .RAMP_DIV   (RD),
        .RAMP_STEP  (STEP),
        .DUTY_FAST  (FAST),
        .DUTY_SLOW  (SLOW),
        .DUTY_SPIN  (SPIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: state of the machine as the spec describes it.
    logic [1:0] m_dir  [2];
    int         m_duty [2];
    int         m_cmp  [2];
    logic       m_pwm  [2];
    int         m_cnt;
    int         m_pre;
    logic [2:0] m_st;
    logic       m_settled;

    always @(posedge clk) begin
        logic [1:0] tdir [2];
        int         td   [2];
        int         eff;
        int         dlt;
        logic       s;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_dir[c]  <= FWD;
                m_duty[c] <= 0;
                m_cmp[c]  <= 0;
                m_pwm[c]  <= 1'b0;
            end
            m_cnt     <= 0;
            m_pre     <= 0;
            m_st      <= 3'd0;
            m_settled <= 1'b0;
        end else begin
            tdir[0] = m_dir[0];
            tdir[1] = m_dir[1];
            td      = '{0, 0};
            if (bus.enable) begin
                case (m_st)
                    3'd0: begin tdir = '{REV, FWD}; td = '{SPIN, SPIN}; end
                    3'd1: begin tdir = '{FWD, FWD}; td = '{0, FAST};    end
                    3'd2: begin tdir = '{FWD, FWD}; td = '{SLOW, FAST}; end
                    3'd3: begin tdir = '{FWD, FWD}; td = '{FAST, SLOW}; end
                    3'd4: begin tdir = '{FWD, FWD}; td = '{FAST, 0};    end
                    3'd5: begin tdir = '{FWD, REV}; td = '{SPIN, SPIN}; end
                    default: ;
                endcase
            end
            s = 1'b1;
            for (int c = 0; c < 2; c++) begin
                s   = s && (m_duty[c] == td[c]) && (m_dir[c] == tdir[c]);
                eff = (tdir[c] != m_dir[c]) ? 0 : td[c];
                dlt = eff - m_duty[c];
                if (dlt > STEP)  dlt = STEP;
                if (dlt < -STEP) dlt = -STEP;
                if (m_pre == RD - 1)
                    m_duty[c] <= m_duty[c] + dlt;
                if (m_duty[c] == 0 && tdir[c] != m_dir[c])
                    m_dir[c] <= tdir[c];
                if (m_cnt == P - 1)
                    m_cmp[c] <= m_duty[c];
                m_pwm[c] <= (m_cnt < m_cmp[c]);
            end
            m_settled <= s;
            m_cnt     <= (m_cnt == P - 1)  ? 0 : m_cnt + 1;
            m_pre     <= (m_pre == RD - 1) ? 0 : m_pre + 1;
            m_st      <= bus.state;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_l",   32'(bus.pwm_l),   32'(m_pwm[0]));
            check("pwm_r",   32'(bus.pwm_r),   32'(m_pwm[1]));
            check("dir_l",   32'(bus.dir_l),   32'(m_dir[0]));
            check("dir_r",   32'(bus.dir_r),   32'(m_dir[1]));
            check("settled", 32'(bus.settled), 32'(m_settled));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pwm(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            hl += int'(bus.pwm_l);
            hr += int'(bus.pwm_r);
        end
    endtask

    initial begin
        int hl;
        int hr;
        int guard;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.state  = 3'd0;
        run(3);
        check("rst_pwm_l",   32'(bus.pwm_l),   32'd0);
        check("rst_pwm_r",   32'(bus.pwm_r),   32'd0);
        check("rst_dir_l",   32'(bus.dir_l),   32'(FWD));
        check("rst_dir_r",   32'(bus.dir_r),   32'(FWD));
        check("rst_settled", 32'(bus.settled), 32'd0);
        chk_on = 1'b1;

        // Gentle left from rest, then duty pattern over one full period.
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.state  = 3'd2;
        run(40);
        check("s2_settled", 32'(bus.settled), 32'd1);
        count_pwm(hl, hr);
        check("s2_high_l", 32'(hl), 32'(SLOW));
        check("s2_high_r", 32'(hr), 32'(FAST));

        // Pivot recovery forces a left reversal through zero.
        bus.state = 3'd0;
        run(50);
        check("s0_dir_l", 32'(bus.dir_l), 32'(REV));
        count_pwm(hl, hr);
        check("s0_high_l", 32'(hl), 32'(SPIN));

        // Back to forward, then disable.
        bus.state = 3'd3;
        run(50);
        bus.enable = 1'b0;
        run(40);
        count_pwm(hl, hr);
        check("dis_high_l", 32'(hl), 32'd0);
        check("dis_high_r", 32'(hr), 32'd0);
        check("dis_settled", 32'(bus.settled), 32'd1);

        // Illegal class coasts with directions held, then recover.
        bus.enable = 1'b1;
        bus.state  = 3'd4;
        run(40);
        bus.state = 3'd7;
        run(30);
        bus.state = 3'd4;
        run(40);

        // Reset mid-ramp.
        bus.state = 3'd2;
        run(12);
        reset = 1'b1;
        run(1);
        check("mid_rst_pwm_r", 32'(bus.pwm_r), 32'd0);
        reset = 1'b0;
        run(40);

        // Class change at counter 3 must not disturb the current period.
        guard = 0;
        while (m_cnt != 3 && guard < 4 * P) begin
            run(1);
            guard++;
        end
        check("align_cnt3", 32'(m_cnt), 32'd3);
        bus.state = 3'd3;
        run(30);

        // Random class/enable/reset sequences.
        for (int seg = 0; seg < 150; seg++) begin
            bus.state  = 3'($urandom_range(0, 7));
            bus.enable = ($urandom_range(0, 7) != 0);
            reset      = ($urandom_range(0, 29) == 0);
            run(1);
            reset = 1'b0;
            run($urandom_range(1, 40));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
